// File: rtl/shift_sequencer.sv
// Control stage for an external WIDTH-bit rotating shift register: loads a word,
// rotates it a programmed number of steps, then holds it by reloading q onto D.
module shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_left_req,
   input  logic [CNT_W-1:0] steps,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] D_out,
   output logic             parallel_loadn,
   output logic             load_left,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] data_r;
   logic             dir_r;
   logic [CNT_W-1:0] cnt;

   // The step count is captured straight into cnt on start; it holds through LOAD,
   // so cnt in LOAD is the latched request.
   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= IDLE;
         data_r <= '0;
         dir_r  <= 1'b0;
         cnt    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  data_r <= data_in;
                  dir_r  <= load_left_req;
                  cnt    <= steps;
               end
            end
            SHIFT: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // NOTE: every output is given a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt      = state;
      D_out          = q_in;
      parallel_loadn = 1'b0;
      load_left      = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            D_out     = data_r;
            busy      = 1'b1;
            state_nxt = (cnt != '0) ? SHIFT : DONE;
         end
         SHIFT: begin
            D_out          = data_r;
            parallel_loadn = 1'b1;
            load_left      = dir_r;
            busy           = 1'b1;
            // cnt==1 is the last rotation; <=1 keeps a corrupted zero from wrapping.
            if (cnt <= CNT_W'(1)) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: drives a behavioural 8-bit rotating register from shift_sequencer
// and checks the register contents and the control outputs cycle by cycle.
module tb_shift_sequencer;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clock;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] data_in;
   logic             load_left_req;
   logic [CNT_W-1:0] steps;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] D_out;
   logic             parallel_loadn;
   logic             load_left;
   logic             busy;
   logic             done;

   int passed = 0;
   int total  = 0;

   shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .data_in        (data_in),
      .load_left_req  (load_left_req),
      .steps          (steps),
      .q_in           (q),
      .D_out          (D_out),
      .parallel_loadn (parallel_loadn),
      .load_left      (load_left),
      .busy           (busy),
      .done           (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Rotating register: load_left=1 moves bit i+1 into i with bit 0 wrapping to the top.
   always @(posedge clock) begin
      if (!reset)              q <= '0;
      else if (!parallel_loadn) q <= D_out;
      else if (load_left)      q <= {q[0], q[WIDTH-1:1]};
      else                     q <= {q[WIDTH-2:0], q[WIDTH-1]};
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Returns #1 after the edge that samples start (edge k); inputs then scrambled.
   task automatic issue(input logic [WIDTH-1:0] d, input logic dir, input logic [CNT_W-1:0] n);
      start = 1'b1; data_in = d; load_left_req = dir; steps = n;
      step();
      start = 1'b0; data_in = ~d; load_left_req = ~dir; steps = ~n;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step();
      step();
      total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else passed++;
      total++; if (parallel_loadn !== 1'b0) $display("FAIL rst_pl: got %b expected 0", parallel_loadn); else passed++;
      total++; if (load_left !== 1'b0) $display("FAIL rst_ll: got %b expected 0", load_left); else passed++;
      total++; if (q !== 8'h00) $display("FAIL rst_q: got %h expected 00", q); else passed++;
      reset = 1'b1;
      step();
      total++; if (D_out !== 8'h00) $display("FAIL rst_dout_hold: got %h expected 00", D_out); else passed++;
   endtask

   task automatic test_rotate_left_one();
      issue(8'b1000_0001, 1'b1, 4'd1);
      total++; if (busy !== 1'b1) $display("FAIL t1_busy_load: got %b expected 1", busy); else passed++;
      step();
      total++; if (q !== 8'h81) $display("FAIL t1_q_loaded: got %h expected 81", q); else passed++;
      total++; if (load_left !== 1'b1) $display("FAIL t1_ll_shift: got %b expected 1", load_left); else passed++;
      step();
      total++; if (q !== 8'hC0) $display("FAIL t1_q_rot: got %h expected c0", q); else passed++;
      total++; if (done !== 1'b1) $display("FAIL t1_done: got %b expected 1", done); else passed++;
      total++; if (load_left !== 1'b0) $display("FAIL t1_ll_done: got %b expected 0", load_left); else passed++;
      step();
      total++; if (done !== 1'b0) $display("FAIL t1_done_pulse: got %b expected 0", done); else passed++;
      for (int i = 0; i < 20; i++) begin
         step();
         total++; if (q !== 8'hC0) $display("FAIL t1_hold_%0d: got %h expected c0", i, q); else passed++;
      end
   endtask

   task automatic test_rotate_right_one();
      issue(8'b1000_0001, 1'b0, 4'd1);
      total++; if (load_left !== 1'b0) $display("FAIL t2_ll_load: got %b expected 0", load_left); else passed++;
      step();
      total++; if (load_left !== 1'b0) $display("FAIL t2_ll_shift: got %b expected 0", load_left); else passed++;
      total++; if (parallel_loadn !== 1'b1) $display("FAIL t2_pl_shift: got %b expected 1", parallel_loadn); else passed++;
      step();
      total++; if (q !== 8'h03) $display("FAIL t2_q: got %h expected 03", q); else passed++;
      total++; if (done !== 1'b1) $display("FAIL t2_done: got %b expected 1", done); else passed++;
      total++; if (load_left !== 1'b0) $display("FAIL t2_ll_done: got %b expected 0", load_left); else passed++;
      step();
      total++; if (q !== 8'h03) $display("FAIL t2_hold: got %h expected 03", q); else passed++;
   endtask

   task automatic test_full_wrap();
      int cycles = 0;
      issue(8'hA5, 1'b1, 4'd8);
      while (busy && cycles < 40) begin
         cycles++;
         step();
      end
      total++; if (cycles !== 9) $display("FAIL t3_busy_cycles: got %0d expected 9", cycles); else passed++;
      total++; if (done !== 1'b1) $display("FAIL t3_done: got %b expected 1", done); else passed++;
      total++; if (q !== 8'hA5) $display("FAIL t3_q: got %h expected a5", q); else passed++;
      step();
      step();
      total++; if (q !== 8'hA5) $display("FAIL t3_no_extra: got %h expected a5", q); else passed++;
   endtask

   task automatic test_zero_steps();
      issue(8'h3C, 1'b0, 4'd0);
      total++; if (parallel_loadn !== 1'b0) $display("FAIL t4_pl_load: got %b expected 0", parallel_loadn); else passed++;
      step();
      total++; if (q !== 8'h3C) $display("FAIL t4_q: got %h expected 3c", q); else passed++;
      total++; if (done !== 1'b1) $display("FAIL t4_done: got %b expected 1", done); else passed++;
      total++; if (parallel_loadn !== 1'b0) $display("FAIL t4_pl_done: got %b expected 0", parallel_loadn); else passed++;
      step();
      total++; if (done !== 1'b0) $display("FAIL t4_done_pulse: got %b expected 0", done); else passed++;
      total++; if (q !== 8'h3C) $display("FAIL t4_hold: got %h expected 3c", q); else passed++;
   endtask

   task automatic test_start_ignored();
      issue(8'b1000_0001, 1'b1, 4'd3);
      step();
      start = 1'b1; data_in = 8'hFF; load_left_req = 1'b0; steps = 4'd7;
      step();
      start = 1'b0;
      total++; if (q !== 8'hC0) $display("FAIL t5_q_mid: got %h expected c0", q); else passed++;
      step();
      total++; if (busy !== 1'b1) $display("FAIL t5_busy: got %b expected 1", busy); else passed++;
      step();
      total++; if (done !== 1'b1) $display("FAIL t5_done: got %b expected 1", done); else passed++;
      total++; if (q !== 8'h30) $display("FAIL t5_q: got %h expected 30", q); else passed++;
      step();
      step();
      total++; if (busy !== 1'b0) $display("FAIL t5_not_queued: got %b expected 0", busy); else passed++;
      total++; if (q !== 8'h30) $display("FAIL t5_hold: got %h expected 30", q); else passed++;
   endtask

   task automatic test_reset_mid_shift();
      issue(8'hA5, 1'b0, 4'd5);
      step();
      step();
      total++; if (q !== 8'h4B) $display("FAIL t6_q_rot: got %h expected 4b", q); else passed++;
      reset = 1'b0;
      step();
      total++; if (busy !== 1'b0) $display("FAIL t6_busy: got %b expected 0", busy); else passed++;
      total++; if (parallel_loadn !== 1'b0) $display("FAIL t6_pl: got %b expected 0", parallel_loadn); else passed++;
      total++; if (load_left !== 1'b0) $display("FAIL t6_ll: got %b expected 0", load_left); else passed++;
      total++; if (done !== 1'b0) $display("FAIL t6_done: got %b expected 0", done); else passed++;
      total++; if (q !== 8'h00) $display("FAIL t6_q: got %h expected 00", q); else passed++;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         total++; if (q !== 8'h00 || busy !== 1'b0) $display("FAIL t6_stay_%0d: got q=%h busy=%b expected q=00 busy=0", i, q, busy); else passed++;
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; data_in = '0; load_left_req = 1'b0; steps = '0;
      test_reset();
      test_rotate_left_one();
      test_rotate_right_one();
      test_full_wrap();
      test_zero_steps();
      test_start_ignored();
      test_reset_mid_shift();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
